cpu64_l1_wbuf: RTL and testbench
================================

# cpu64_l1_wbuf

Write buffer between the L1 D$ memory-side host port and the L2/memory slave port. Absorbs dirty-line writeback beats at one per cycle, then drains them downstream in order. Passes refill reads through strictly after all buffered writes and their downstream responses complete, so a read never overtakes an older write or consumes a stale write response.

## Interface
- DEPTH, 8: write-buffer entries (64-bit beats); power of two, ≥2; 8 holds one full 64B line
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i / we_i  in  1 / 1  upstream request from L1; write select
- be_i  in  8  byte enables
- addr_i / wdata_i  in  64 / 64  beat address; write data
- gnt_o  out  1  combinational grant to L1
- rvalid_o  out  1  registered response valid
- rdata_o  out  64  registered read data
- req_o / we_o  out  1 / 1  downstream request; write select
- be_o  out  8  downstream byte enables
- addr_o / wdata_o  out  64 / 64  downstream address; data
- gnt_i / rvalid_i  in  1 / 1  downstream grant; response valid
- rdata_i  in  64  downstream read data
- busy_o  out  1  buffer non-empty, or write responses outstanding, or read in flight; used for fences

## Operation
- FIFO entries hold {addr[63:0], be[7:0], wdata[63:0]}. Pointers are log2(DEPTH)+1 bits. full: MSBs differ and the low bits are equal. empty: pointers equal.
- wr_out counter, log2(DEPTH)+2 bits: +1 on each downstream write handshake, −1 on each rvalid_i while reads are not in flight. Simultaneous +1/−1 leaves it unchanged. A decrement at 0 is ignored and flagged by an assertion.
- FSM states: S_IDLE, S_RD_REQ, S_RD_WAIT.
- S_IDLE, upstream write:
  - gnt_o = req_i && we_i && !full. A granted write pushes the FIFO.
  - rvalid_o pulses the next cycle with rdata_o = 0.
- S_IDLE, drain:
  - When !empty and wr_out is not at max: req_o=1, we_o=1, and the FIFO head drives be_o/addr_o/wdata_o.
  - gnt_i pops the head.
  - Push and pop in the same cycle are both legal when full; full then stays asserted.
- S_IDLE, upstream read:
  - gnt_o = req_i && !we_i && empty && wr_out==0.
  - On grant, latch addr_i and be_i, then go to S_RD_REQ.
  - A read request that is not granted waits. No read is dropped.
- S_RD_REQ: req_o=1, we_o=0, latched address/be on the outputs. gnt_i → S_RD_WAIT.
- S_RD_WAIT: on rvalid_i, register rvalid_o=1 and rdata_o=rdata_i, then go to S_IDLE.
- No upstream grant in S_RD_REQ or S_RD_WAIT, for writes or reads.
- Downstream outputs are 0 whenever req_o=0.

## Timing
- Reset values:
  - gnt_o=0, rvalid_o=0, rdata_o=0, req_o=0, we_o=0, be_o=0, addr_o=0, wdata_o=0, busy_o=0.
  - FIFO empty, wr_out=0, state S_IDLE.
- Reset mid-operation discards buffered data and in-flight reads.
- Write acceptance: 0-cycle grant. rvalid_o follows at +1 cycle.
- Write drain: an entry pushed in cycle N can appear on req_o in cycle N+1 at the earliest (registered storage). Throughput is 1 beat/cycle with continuous gnt_i.
- Read latency: gnt_o in N → req_o in N+1 → downstream gnt_i at G → rvalid_i at R → rvalid_o at R+1.
- Downstream req_o is held stable, with unchanged address/data, until gnt_i.
- busy_o is combinational from the FIFO, wr_out and state.

## Structure
- Shared constants go in cpu64_mem_pkg:
  - ADDR_W=64, DATA_W=64, BE_W=8
  - packed wbuf entry type {addr, be, wdata}
- One sub-module: cpu64_sync_fifo, parameterised by width and depth, with push/pop/full/empty and a registered head.
- The top holds the FSM, wr_out and the output muxing.

## Test plan
- 8 back-to-back writes, addr 0x1000..0x1038, gnt_i held 1 → 8 grants in 8 cycles; 8 downstream writes in the same order with identical data; busy_o drops after the 8th rvalid_i.
- 9 writes with gnt_i held 0 → the 9th write is not granted while full; the first gnt_i pop allows it in the same cycle.
- Writes to 0x2000..0x2038 followed immediately by a read of 0x4000 → the read is granted only after the FIFO is empty and wr_out==0; req_o shows the read after the last write response.
- Read with rvalid_i delayed 5 cycles, rdata_i=0xDEADBEEF_CAFEF00D → rvalid_o one cycle after rvalid_i with that data; no upstream grants in between.
- Downstream gnt_i random 50%, 3 full-line writebacks interleaved with reads → no reordering; every read returns its own data.
- rst_ni pulsed low with 4 entries buffered and a read in S_RD_WAIT → all outputs 0; busy_o=0; the next write is granted immediately.

Source files
------------

// File: rtl/cpu64_mem_pkg.sv
`default_nettype none
//============================================================================
// Module : cpu64_mem_pkg
// Brief  : Shared memory-port widths, write-buffer entry and FSM state types.
// Rev    : 1.0
//============================================================================
package cpu64_mem_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } wbuf_entry_t;

    localparam int WBUF_ENTRY_W = $bits(wbuf_entry_t);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_REQ  = 2'd1,
        S_RD_WAIT = 2'd2
    } wbuf_state_e;

endpackage
`default_nettype wire

// File: rtl/cpu64_sync_fifo.sv
`default_nettype none
//============================================================================
// Module : cpu64_sync_fifo
// Brief  : Flop-based synchronous FIFO with registered head and pass-through
//          push when a pop frees the slot in the same cycle.
// Rev    : 1.0
//============================================================================
module cpu64_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full_o    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign empty_o   = (r_wr_ptr == r_rd_ptr);
    assign w_pop_ok  = pop_i && !empty_o;
    assign w_push_ok = push_i && (!full_o || w_pop_ok);
    assign head_o    = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) r_mem[r_wr_ptr[c_aw-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/cpu64_l1_wbuf.sv
`default_nettype none
//============================================================================
// Module : cpu64_l1_wbuf
// Brief  : L1 D$ write buffer; drains writebacks in order and holds refill
//          reads until every older write has been acknowledged downstream.
// Rev    : 1.0
//============================================================================
module cpu64_l1_wbuf
    import cpu64_mem_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              req_o,
    output logic              we_o,
    output logic [BE_W-1:0]   be_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic              gnt_i,
    input  logic              rvalid_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              busy_o
);

    localparam int c_cnt_w = $clog2(DEPTH) + 2;
    localparam logic [c_cnt_w-1:0] c_cnt_max = '1;

    wbuf_state_e        r_state;
    wbuf_state_e        w_state_nxt;
    logic [c_cnt_w-1:0] r_wr_out;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [BE_W-1:0]    r_rd_be;
    logic               r_rvalid;
    logic [DATA_W-1:0]  r_rdata;

    wbuf_entry_t        w_head;
    wbuf_entry_t        w_push_entry;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_rd_grant;
    logic               w_dec;

    assign w_push_entry = '{addr: addr_i, be: be_i, wdata: wdata_i};

    cpu64_sync_fifo #(
        .WIDTH (WBUF_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .wdata_i (w_push_entry),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        gnt_o       = 1'b0;
        req_o       = 1'b0;
        we_o        = 1'b0;
        be_o        = '0;
        addr_o      = '0;
        wdata_o     = '0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_rd_grant  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && (r_wr_out != c_cnt_max)) begin
                    req_o   = 1'b1;
                    we_o    = 1'b1;
                    be_o    = w_head.be;
                    addr_o  = w_head.addr;
                    wdata_o = w_head.wdata;
                    w_pop   = gnt_i;
                end
                // A pop this cycle frees a slot, so a full buffer can still accept.
                if (req_i && we_i && (!w_full || w_pop)) begin
                    gnt_o  = 1'b1;
                    w_push = 1'b1;
                end else if (req_i && !we_i && w_empty && (r_wr_out == '0)) begin
                    gnt_o       = 1'b1;
                    w_rd_grant  = 1'b1;
                    w_state_nxt = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                req_o  = 1'b1;
                be_o   = r_rd_be;
                addr_o = r_rd_addr;
                if (gnt_i) w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (rvalid_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Only write responses arrive in S_IDLE; reads are tracked by the FSM.
    assign w_dec = rvalid_i && (r_state == S_IDLE) && (r_wr_out != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_wr_out  <= '0;
            r_rd_addr <= '0;
            r_rd_be   <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case ({w_pop, w_dec})
                2'b10:   r_wr_out <= r_wr_out + 1'b1;
                2'b01:   r_wr_out <= r_wr_out - 1'b1;
                default: r_wr_out <= r_wr_out;
            endcase
            if (w_rd_grant) begin
                r_rd_addr <= addr_i;
                r_rd_be   <= be_i;
            end
            r_rvalid <= w_push || ((r_state == S_RD_WAIT) && rvalid_i);
            r_rdata  <= ((r_state == S_RD_WAIT) && rvalid_i) ? rdata_i : '0;
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign busy_o   = !w_empty || (r_wr_out != '0) || (r_state != S_IDLE);

`ifndef SYNTHESIS
    a_wr_out_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rvalid_i && (r_state == S_IDLE) && (r_wr_out == '0)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu64_l1_wbuf.sv
`default_nettype none
//============================================================================
// Module : tb_cpu64_l1_wbuf
// Brief  : Randomised bench for cpu64_l1_wbuf against a queue-based model.
// Rev    : 1.0
//============================================================================
module tb_cpu64_l1_wbuf;

    localparam int DEPTH   = 8;
    localparam int CNT_MAX = 4 * DEPTH - 1;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0, we_i = 1'b0;
    logic [7:0]  be_i = '0;
    logic [63:0] addr_i = '0, wdata_i = '0;
    logic        gnt_o, rvalid_o, req_o, we_o, busy_o;
    logic [63:0] rdata_o, addr_o, wdata_o;
    logic [7:0]  be_o;
    logic        gnt_i = 1'b0, rvalid_i = 1'b0;
    logic [63:0] rdata_i = '0;

    always #5 clk = ~clk;

    cpu64_l1_wbuf #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: buffered writes, outstanding write acks, read phase
    typedef struct packed {logic [63:0] addr; logic [7:0] be; logic [63:0] data;} ent_t;
    ent_t        m_q[$];
    int          m_out = 0;
    int          m_rd = 0;               // 0 none, 1 waiting for gnt_i, 2 waiting for data
    logic [63:0] m_rd_addr = '0;
    logic [7:0]  m_rd_be = '0;
    logic        m_rv = 1'b0;
    logic [63:0] m_rdata = '0;

    // Downstream slave: in-order response queue
    typedef struct {int due; logic [63:0] data;} rsp_t;
    rsp_t        s_q[$];
    int          cyc = 0;
    int          gnt_mode = 1;           // 0 never, 1 always, 2 random
    int          dly_min = 1, dly_max = 1;
    bit          rd_ovr = 1'b0;
    logic [63:0] rd_ovr_val = '0;

    logic        u_req = 1'b0, u_we = 1'b0;
    logic [63:0] u_addr = '0, u_wdata = '0;
    logic [7:0]  u_be = '0;
    bit          last_gnt = 1'b0;
    int          dut_gnts = 0;

    task automatic step();
        ent_t        h;
        bit          e_req, e_we, e_pop, e_gnt, e_busy;
        logic [63:0] e_addr, e_wdata;
        logic [7:0]  e_be;
        rsp_t        r;
        @(posedge clk);
        #1;
        cyc++;
        req_i = u_req; we_i = u_we; addr_i = u_addr; be_i = u_be; wdata_i = u_wdata;
        case (gnt_mode)
            0:       gnt_i = 1'b0;
            1:       gnt_i = 1'b1;
            default: gnt_i = 1'($urandom_range(0, 1));
        endcase
        if (s_q.size() > 0 && s_q[0].due <= cyc) begin
            rvalid_i = 1'b1;
            rdata_i  = s_q[0].data;
            s_q.delete(0);
        end else begin
            rvalid_i = 1'b0;
            rdata_i  = {$urandom, $urandom};
        end
        #3;
        h       = (m_q.size() > 0) ? m_q[0] : '0;
        e_req   = (m_rd == 1) || (m_rd == 0 && m_q.size() > 0 && m_out < CNT_MAX);
        e_we    = (m_rd == 0) && e_req;
        e_addr  = !e_req ? 64'd0 : (e_we ? h.addr : m_rd_addr);
        e_be    = !e_req ? 8'd0  : (e_we ? h.be   : m_rd_be);
        e_wdata = e_we ? h.data : 64'd0;
        e_pop   = e_we && gnt_i;
        e_gnt   = (m_rd == 0) && u_req &&
                  (u_we ? (m_q.size() < DEPTH || e_pop) : (m_q.size() == 0 && m_out == 0));
        e_busy  = (m_q.size() > 0) || (m_out > 0) || (m_rd != 0);
        check("gnt_o",    64'(gnt_o),    64'(e_gnt));
        check("req_o",    64'(req_o),    64'(e_req));
        check("we_o",     64'(we_o),     64'(e_we));
        check("addr_o",   addr_o,        e_addr);
        check("be_o",     64'(be_o),     64'(e_be));
        check("wdata_o",  wdata_o,       e_wdata);
        check("rvalid_o", 64'(rvalid_o), 64'(m_rv));
        check("rdata_o",  rdata_o,       m_rdata);
        check("busy_o",   64'(busy_o),   64'(e_busy));
        if (gnt_o) dut_gnts++;
        // Slave accepts the handshake the model expects
        if (e_req && gnt_i) begin
            r.due  = cyc + int'($urandom_range(dly_min, dly_max));
            r.data = (!e_we && rd_ovr) ? rd_ovr_val : {$urandom, $urandom};
            s_q.push_back(r);
        end
        m_rdata = (m_rd == 2 && rvalid_i) ? rdata_i : 64'd0;
        m_rv    = (e_gnt && u_we) || (m_rd == 2 && rvalid_i);
        if (m_rd == 0 && rvalid_i && m_out > 0) m_out--;
        if (e_pop) begin
            m_out++;
            m_q.delete(0);
        end
        if (e_gnt && u_we) m_q.push_back('{addr: u_addr, be: u_be, data: u_wdata});
        case (m_rd)
            0: if (e_gnt && !u_we) begin
                   m_rd = 1; m_rd_addr = u_addr; m_rd_be = u_be;
               end
            1: if (gnt_i) m_rd = 2;
            default: if (rvalid_i) m_rd = 0;
        endcase
        last_gnt = e_gnt;
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d, output int waits);
        u_req = 1'b1; u_we = 1'b1; u_addr = a; u_wdata = d; u_be = 8'($urandom);
        waits = 0;
        forever begin
            step();
            if (last_gnt) break;
            waits++;
            if (waits > 300) begin
                check("wr_timeout", 64'd1, 64'd0);
                break;
            end
        end
        u_req = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] a);
        int waits;
        u_req = 1'b1; u_we = 1'b0; u_addr = a; u_wdata = '0; u_be = 8'($urandom);
        waits = 0;
        forever begin
            step();
            if (last_gnt) break;
            waits++;
            if (waits > 300) begin
                check("rd_timeout", 64'd1, 64'd0);
                break;
            end
        end
        u_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_o || rvalid_o) && n < 300) begin
            step();
            n++;
        end
        check("idle_timeout", 64'(busy_o || rvalid_o), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        req_i = 1'b0; we_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0; u_req = 1'b0;
        #1;
        check("rst_gnt",    64'(gnt_o),    64'd0);
        check("rst_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_rdata",  rdata_o,       64'd0);
        check("rst_req",    64'(req_o),    64'd0);
        check("rst_we",     64'(we_o),     64'd0);
        check("rst_be",     64'(be_o),     64'd0);
        check("rst_addr",   addr_o,        64'd0);
        check("rst_wdata",  wdata_o,       64'd0);
        check("rst_busy",   64'(busy_o),   64'd0);
        m_q.delete(); s_q.delete();
        m_out = 0; m_rd = 0; m_rv = 1'b0; m_rdata = '0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        int w, c0, g0;
        do_reset();

        // Line writeback with continuous downstream grant
        gnt_mode = 1; dly_min = 1; dly_max = 1;
        c0 = cyc; g0 = dut_gnts;
        for (int i = 0; i < 8; i++) begin
            do_write(64'h1000 + 64'(8 * i), {$urandom, $urandom}, w);
            check("b2b_wait", 64'(w), 64'd0);
        end
        check("b2b_cycles", 64'(cyc - c0), 64'd8);
        check("b2b_gnts", 64'(dut_gnts - g0), 64'd8);
        wait_idle();

        // Fill with downstream stalled, then pop-through on the 9th write
        gnt_mode = 0;
        for (int i = 0; i < 8; i++) do_write(64'h3000 + 64'(8 * i), {$urandom, $urandom}, w);
        u_req = 1'b1; u_we = 1'b1; u_addr = 64'h3040; u_wdata = 64'h1234_5678_9abc_def0; u_be = 8'hff;
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_nogrant", 64'(gnt_o), 64'd0);
        end
        gnt_mode = 1;
        step();
        check("full_popthru", 64'(gnt_o), 64'd1);
        u_req = 1'b0;
        wait_idle();

        // Read queued behind a writeback
        dly_min = 1; dly_max = 3;
        for (int i = 0; i < 8; i++) do_write(64'h2000 + 64'(8 * i), {$urandom, $urandom}, w);
        do_read(64'h4000);
        wait_idle();

        // Slow read response with a known data pattern
        dly_min = 5; dly_max = 5; rd_ovr = 1'b1; rd_ovr_val = 64'hDEAD_BEEF_CAFE_F00D;
        do_read(64'h5000);
        u_req = 1'b1; u_we = 1'b1; u_addr = 64'h6000; u_wdata = 64'h1;
        c0 = 0;
        while (!rvalid_o && c0 < 50) begin
            step();
            c0++;
        end
        check("slow_rvalid", 64'(rvalid_o), 64'd1);
        check("slow_rdata",  rdata_o, 64'hDEAD_BEEF_CAFE_F00D);
        u_req = 1'b0; rd_ovr = 1'b0;
        wait_idle();

        // Random downstream grant, line writebacks interleaved with reads
        gnt_mode = 2; dly_min = 1; dly_max = 4;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++)
                do_write(64'h8000 + 64'(64 * k + 8 * i), {$urandom, $urandom}, w);
            do_read(64'h9000 + 64'(8 * k));
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) step();
        end
        wait_idle();

        // Reset with buffered writes, then with a read awaiting data
        gnt_mode = 0; dly_min = 1; dly_max = 1;
        for (int i = 0; i < 4; i++) do_write(64'hA000 + 64'(8 * i), {$urandom, $urandom}, w);
        do_reset();
        gnt_mode = 1; dly_min = 30; dly_max = 30;
        do_read(64'hB000);
        for (int i = 0; i < 3; i++) step();
        do_reset();
        dly_min = 1; dly_max = 1;
        do_write(64'hC000, 64'h55, w);
        check("post_rst_wait", 64'(w), 64'd0);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
